ex_muldiv_unit: RTL

EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/div_step.sv | 25 ++
 rtl/ex_muldiv_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the M-extension multiply/divide unit: funct3 ops, FSM states, XLEN default.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU);
    endfunction

    function automatic logic op_div_signed(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in next dividend bit, trial-subtract divisor.
// Combinational; only built when EX_MULDIV_DIV_EN is defined.
`ifdef EX_MULDIV_DIV_EN
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_dvsr,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_trial;
    logic [XLEN:0] w_diff;
    logic          w_ge;

    assign w_trial = {i_rem, i_quo[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, i_dvsr};
    assign w_ge    = (w_trial >= {1'b0, i_dvsr});
    assign o_rem   = w_ge ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
    assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule
`endif

// File: rtl/ex_muldiv_unit.sv
// Iterative RV M-extension unit; mul XLEN/MUL_BITS_PER_CYCLE+1 cycles, div XLEN+2 (EX_MULDIV_DIV_EN), bypass 1.
// Result held in DONE until ready_i; ready_o drops for one cycle after every return to IDLE.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN               = XLEN_DEFAULT,
    parameter int MUL_BITS_PER_CYCLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            busy_o
);

    localparam int MUL_ITERS = XLEN / MUL_BITS_PER_CYCLE;
    localparam int CNT_W     = $clog2(XLEN) + 1;
    localparam int AW        = 2 * XLEN;

    muldiv_state_e   r_state, w_state_nxt;
    logic            r_idle_q;
    logic [CNT_W-1:0] r_cnt;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_result;
    logic            r_mul_lo;
    logic            r_b_corr;
    logic [XLEN-1:0] r_a;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_mcand;
    logic [XLEN-1:0] r_mplier;

    logic            w_accept;
    logic            w_bypass;
    logic [XLEN-1:0] w_bypass_res;
    logic            w_calc_last;
    logic            w_mul_last;
    logic            w_a_sext;
    logic [AW-1:0]   w_partial;
    logic [AW-1:0]   w_acc_nxt;

    assign ready_o   = (r_state == ST_IDLE) && r_idle_q && !flush_i;
    assign w_accept  = valid_i && ready_o;
    assign valid_o   = (r_state == ST_DONE);
    assign busy_o    = (r_state != ST_IDLE);
    assign result_o  = r_result;
    assign rd_addr_o = r_rd;

    // Multiplier: unsigned digits of B; a signed B's MSB carries weight -2^(XLEN-1),
    // fixed up by subtracting A<<XLEN on the last iteration.
    assign w_a_sext   = op_a_signed(op_i) && operand_a_i[XLEN-1];
    assign w_mul_last = (r_cnt == CNT_W'(MUL_ITERS - 1));

    always_comb begin
        w_partial = '0;
        for (int b = 0; b < MUL_BITS_PER_CYCLE; b++) begin
            if (r_mplier[b]) begin
                w_partial = w_partial + (r_mcand << b);
            end
        end
    end

    assign w_acc_nxt = r_acc + w_partial
                     - ((w_mul_last && r_b_corr) ? {r_a, {XLEN{1'b0}}} : {AW{1'b0}});

`ifdef EX_MULDIV_DIV_EN
    logic            r_is_div;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_div_last;
    logic            w_a_neg;
    logic            w_b_neg;
    logic            w_div_zero;
    logic            w_div_ovf;

    div_step #(.XLEN(XLEN)) u_div_step (
        .i_rem  (r_rem),
        .i_quo  (r_quo),
        .i_dvsr (r_dvsr),
        .o_rem  (w_rem_nxt),
        .o_quo  (w_quo_nxt)
    );

    assign w_a_neg    = op_div_signed(op_i) && operand_a_i[XLEN-1];
    assign w_b_neg    = op_div_signed(op_i) && operand_b_i[XLEN-1];
    assign w_div_zero = (operand_b_i == '0);
    assign w_div_ovf  = op_div_signed(op_i) && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}})
                     && (operand_b_i == '1);
    assign w_bypass   = op_i[2] && (w_div_zero || w_div_ovf);
    // Cycle XLEN is the sign-correction cycle after the last quotient bit.
    assign w_div_last = (r_cnt == CNT_W'(XLEN));
    assign w_calc_last = r_is_div ? w_div_last : w_mul_last;

    always_comb begin
        w_bypass_res = '0;
        if (w_div_zero) begin
            w_bypass_res = op_i[1] ? operand_a_i : '1;
        end else if (!op_i[1]) begin
            w_bypass_res = operand_a_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
        end else if (r_state == ST_IDLE && w_accept) begin
            r_is_div <= op_i[2];
            r_is_rem <= op_i[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rem    <= '0;
            r_quo    <= w_a_neg ? -operand_a_i : operand_a_i;
            r_dvsr   <= w_b_neg ? -operand_b_i : operand_b_i;
        end else if (r_state == ST_CALC && r_is_div && !w_div_last) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end
`else
    assign w_bypass     = op_i[2];
    assign w_bypass_res = '0;
    assign w_calc_last  = w_mul_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_bypass ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (flush_i)          w_state_nxt = ST_IDLE;
                else if (w_calc_last) w_state_nxt = ST_DONE;
            end
            ST_DONE: if (flush_i || ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_q <= 1'b0;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_mul_lo <= 1'b0;
            r_b_corr <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_idle_q <= (r_state == ST_IDLE);
            if (r_state == ST_IDLE && w_accept) begin
                r_cnt    <= '0;
                r_rd     <= rd_addr_i;
                r_mul_lo <= (op_i == OP_MUL);
                r_b_corr <= (op_i == OP_MULH) && operand_b_i[XLEN-1];
                r_a      <= operand_a_i;
                r_acc    <= '0;
                r_mcand  <= {{XLEN{w_a_sext}}, operand_a_i};
                r_mplier <= operand_b_i;
                if (w_bypass) r_result <= w_bypass_res;
            end else if (r_state == ST_CALC) begin
                r_cnt    <= r_cnt + CNT_W'(1);
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
                r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
`ifdef EX_MULDIV_DIV_EN
                if (r_is_div && w_div_last) begin
                    if (r_is_rem) r_result <= r_neg_r ? -r_rem : r_rem;
                    else          r_result <= r_neg_q ? -r_quo : r_quo;
                end else if (!r_is_div && w_mul_last) begin
                    r_result <= r_mul_lo ? w_acc_nxt[XLEN-1:0] : w_acc_nxt[AW-1:XLEN];
                end
`else
                if (w_mul_last) begin
                    r_result <= r_mul_lo ? w_acc_nxt[XLEN-1:0] : w_acc_nxt[AW-1:XLEN];
                end
`endif
            end
        end
    end

endmodule
